regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the RV32I core, successor to the basic 2R1W file.
- Adds three features:
  - configurable read-port count and depth;
  - optional write-through bypass;
  - a per-register busy scoreboard. Issue reserves the destination register and writeback releases it.
- Sits between decode/issue (read ports, reservation) and writeback (write port). Hazard detection uses the busy flags.

Parameters:
- XLEN, 32: data width of each register.
- NUM_REGS, 32: register count; power of two, at least 2. AW = $clog2(NUM_REGS) is a derived localparam.
- NUM_READ, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = a same-cycle write is visible on the read ports; 0 = reads return pre-write contents.
- ZERO_REG, 1: 1 = register 0 is hardwired to zero and is never busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rd_addr  in  NUM_READ*AW  packed read addresses; port i is bits [i*AW +: AW].
- rd_data  out  NUM_READ*XLEN  packed read data, combinational.
- rd_busy  out  NUM_READ  busy flag of each addressed register, combinational.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- rsv_en  in  1  issue strobe: mark rsv_addr busy.
- rsv_addr  in  AW  register to reserve.
- rsv_conflict  out  1  combinational; high when rsv_en is high and rsv_addr is already busy (WAW hazard).
- flush  in  1  synchronous clear of all busy flags (pipeline flush); data is untouched.
- busy_count  out  AW+1  registered count of currently busy registers.

Behaviour:
- Reset (async assert, sync release):
  - all registers = 0;
  - all busy flags = 0;
  - busy_count = 0.
  - Combinational outputs follow from this state: rd_data = 0, rd_busy = 0, rsv_conflict = 0.
- Read path, zero-cycle latency:
  - rd_data[i] = reg[rd_addr[i]].
  - If BYPASS=1 and wr_en and wr_addr == rd_addr[i] (and not the zero register), rd_data[i] = wr_data and rd_busy[i] = 0.
  - If ZERO_REG=1 and rd_addr[i] == 0: rd_data[i] = 0 and rd_busy[i] = 0 unconditionally.
- Write, at the clock edge when wr_en:
  - reg[wr_addr] <= wr_data;
  - busy[wr_addr] <= 0.
  - The write is ignored entirely when ZERO_REG=1 and wr_addr == 0.
- Reserve, at the clock edge when rsv_en:
  - busy[rsv_addr] <= 1.
  - Ignored when ZERO_REG=1 and rsv_addr == 0.
  - A reserve of an already-busy register is still applied (flag stays 1). rsv_conflict only reports it; issue logic must stall.
- Simultaneous events, same cycle:
  - Write and reserve to the same register: data is written and busy ends at 1 (the new producer wins).
  - Flush with reserve: flush wins; all busy flags end at 0, the reserve is dropped.
  - Flush with write: data is written; busy flags end at 0.
  - Write and reserve to different registers: both apply.
- busy_count:
  - Registered; equals the popcount of the busy flags after the edge.
  - Next value = current + (reserve sets a previously-clear flag) − (write clears a previously-set flag, other than by reserve override).
  - Forced to 0 on flush.
  - Never exceeds NUM_REGS − ZERO_REG; no wrap-around.
- rst asserted mid-operation: all state clears immediately. Pending reservations are lost, and a writeback in the same cycle is discarded.
- Behaviour is undefined for X on any strobe. No other state exists: no FSM, no output registers besides busy_count.

Test Plan:
- Reset, then read x0..x31 on both ports -> all rd_data = 0, rd_busy = 0, busy_count = 0.
- Write x5 = 0xDEADBEEF with rd_addr0 = 5 in the same cycle:
  - BYPASS=1 -> rd_data0 = 0xDEADBEEF that cycle;
  - BYPASS=0 -> 0 that cycle and 0xDEADBEEF the next.
- Write x0 = 0x12345678 and reserve x0 -> rd_data on x0 = 0, rd_busy = 0, busy_count stays 0.
- Reserve x3, then reserve x3 again:
  - rsv_conflict = 1 on the second attempt;
  - busy_count = 1;
  - writeback x3 = 7 -> busy_count = 0, rd_busy clears, rd_data = 7.
- Same-cycle write and reserve of x9, plus a reserve of x10 in the next cycle -> x9 keeps the new data and is busy; busy_count = 2. Then assert flush together with a write of x10 = 1 -> busy_count = 0 and x10 = 1.
- Reserve x1..x4, then assert rst asynchronously between edges -> busy flags, busy_count and all data are 0 immediately, before the next edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with write-through bypass
// and a per-register busy scoreboard for issue/writeback tracking.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_READ = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_READ*AW-1:0]   rd_addr,
    output logic [NUM_READ*XLEN-1:0] rd_data,
    output logic [NUM_READ-1:0]      rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [XLEN-1:0]          wr_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    output logic                     rsv_conflict,
    input  logic                     flush,
    output logic [AW:0]              busy_count
);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [AW:0]         count_nxt;
    logic [AW-1:0]       ra;
    logic                wr_ok;
    logic                rsv_ok;
    logic                cnt_inc;
    logic                cnt_dec;

    // Writes and reservations aimed at a hardwired x0 have no effect.
    assign wr_ok  = wr_en  && !(ZERO_REG && wr_addr  == '0);
    assign rsv_ok = rsv_en && !(ZERO_REG && rsv_addr == '0);

    assign rsv_conflict = rsv_en && busy[rsv_addr];

    // A reserve landing on the register being written keeps it busy,
    // so that write must not be counted as a release.
    assign cnt_inc = rsv_ok && !busy[rsv_addr];
    assign cnt_dec = wr_ok && busy[wr_addr]
                     && !(rsv_ok && rsv_addr == wr_addr);

    // Next busy vector: release on write, set on reserve, flush clears all.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
    end

    // Incremental popcount of the busy flags.
    always_comb begin
        count_nxt = busy_count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = busy_count
                      + {{AW{1'b0}}, cnt_inc}
                      - {{AW{1'b0}}, cnt_dec};
        end
    end

    // Register array storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Scoreboard flags and their registered count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= count_nxt;
        end
    end

    // Zero-latency read ports with optional write-through.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            ra = rd_addr[i*AW +: AW];
            rd_data[i*XLEN +: XLEN] = regs[ra];
            rd_busy[i]              = busy[ra];
            if (BYPASS && wr_ok && wr_addr == ra) begin
                rd_data[i*XLEN +: XLEN] = wr_data;
                rd_busy[i]              = 1'b0;
            end
            if (ZERO_REG && ra == '0) begin
                rd_data[i*XLEN +: XLEN] = '0;
                rd_busy[i]              = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table,
// async-reset sequence, then random traffic against an array model.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [63:0] nb_rd_data;
    logic [1:0]  nb_rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_conflict;
    logic        nb_rsv_conflict;
    logic        flush;
    logic [5:0]  busy_count;
    logic [5:0]  nb_busy_count;

    int tests;
    int failed;

    logic [31:0] mreg  [32];
    bit          mbusy [32];

    regfile_scoreboard #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_conflict(rsv_conflict),
        .flush(flush), .busy_count(busy_count)
    );

    regfile_scoreboard #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_conflict(nb_rsv_conflict),
        .flush(flush), .busy_count(nb_busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic        fl;
        logic [4:0]  a0;
        logic [31:0] e_d0;
        logic        e_b0;
        logic        e_cf;
        logic [31:0] e_nb;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic re,
                          input logic [4:0] ra, input logic fl,
                          input logic [4:0] a0, input logic [4:0] a1);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rsv_en   = re;
        rsv_addr = ra;
        flush    = fl;
        rd_addr  = {a1, a0};
    endtask

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) begin
            mreg[r]  = '0;
            mbusy[r] = 1'b0;
        end
    endfunction

    // Architectural effect of one clock edge, applied rule by rule.
    function automatic void model_edge();
        if (wr_en && wr_addr != 0) begin
            mreg[wr_addr]  = wr_data;
            mbusy[wr_addr] = 1'b0;
        end
        if (rsv_en && rsv_addr != 0) mbusy[rsv_addr] = 1'b1;
        if (flush) begin
            for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
        end
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(mbusy[r]);
        return n;
    endfunction

    // {busy, data} seen by a read port this cycle.
    function automatic logic [32:0] model_read(input logic [4:0] a,
                                               input bit byp);
        if (a == 0) return '0;
        if (byp && wr_en && wr_addr == a) return {1'b0, wr_data};
        return {mbusy[a], mreg[a]};
    endfunction

    task automatic check_comb(input string tag);
        logic [32:0] e;
        logic [4:0]  a;
        for (int p = 0; p < 2; p++) begin
            a = rd_addr[p*5 +: 5];
            e = model_read(a, 1'b1);
            chk($sformatf("%s byp_data%0d", tag, p),
                rd_data[p*32 +: 32], e[31:0]);
            chk($sformatf("%s byp_busy%0d", tag, p),
                32'(rd_busy[p]), 32'(e[32]));
            e = model_read(a, 1'b0);
            chk($sformatf("%s nb_data%0d", tag, p),
                nb_rd_data[p*32 +: 32], e[31:0]);
            chk($sformatf("%s nb_busy%0d", tag, p),
                32'(nb_rd_busy[p]), 32'(e[32]));
        end
        chk({tag, " conflict"}, 32'(rsv_conflict),
            32'(rsv_en && mbusy[rsv_addr]));
    endtask

    task automatic edge_and_count(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, " count"}, 32'(busy_count), 32'(model_count()));
        chk({tag, " nb_count"}, 32'(nb_busy_count), 32'(model_count()));
        @(negedge clk);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();

        //            we wa  wd            re ra  fl a0  d0            b0 cf nb            cnt
        tbl[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  0, 5,  32'hDEADBEEF, 0, 0, 32'h0,        6'd0};
        tbl[1]  = '{1, 0,  32'h12345678, 1, 0,  0, 0,  32'h0,        0, 0, 32'h0,        6'd0};
        tbl[2]  = '{0, 0,  32'h0,        1, 3,  0, 3,  32'h0,        0, 0, 32'h0,        6'd1};
        tbl[3]  = '{0, 0,  32'h0,        1, 3,  0, 3,  32'h0,        1, 1, 32'h0,        6'd1};
        tbl[4]  = '{1, 3,  32'h7,        0, 0,  0, 3,  32'h7,        0, 0, 32'h0,        6'd0};
        tbl[5]  = '{0, 0,  32'h0,        0, 0,  0, 3,  32'h7,        0, 0, 32'h7,        6'd0};
        tbl[6]  = '{1, 9,  32'hA5A5,     1, 9,  0, 9,  32'hA5A5,     0, 0, 32'h0,        6'd1};
        tbl[7]  = '{0, 0,  32'h0,        1, 10, 0, 9,  32'hA5A5,     1, 0, 32'hA5A5,     6'd2};
        tbl[8]  = '{1, 10, 32'h1,        0, 0,  1, 10, 32'h1,        0, 0, 32'h0,        6'd0};
        tbl[9]  = '{0, 0,  32'h0,        0, 0,  0, 10, 32'h1,        0, 0, 32'h1,        6'd0};
        tbl[10] = '{0, 0,  32'h0,        0, 0,  0, 5,  32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 6'd0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state across the whole file on both ports.
        for (int r = 0; r < 32; r++) begin
            rd_addr = {5'(31 - r), 5'(r)};
            #1;
            chk($sformatf("rst data0 x%0d", r), rd_data[31:0], 32'h0);
            chk($sformatf("rst data1 x%0d", r), rd_data[63:32], 32'h0);
            chk($sformatf("rst busy x%0d", r), 32'(rd_busy), 32'h0);
        end
        chk("rst count", 32'(busy_count), 32'h0);
        chk("rst conflict", 32'(rsv_conflict), 32'h0);
        @(negedge clk);

        // Directed vectors.
        for (int v = 0; v < 11; v++) begin
            set_in(tbl[v].we, tbl[v].wa, tbl[v].wd, tbl[v].re,
                   tbl[v].ra, tbl[v].fl, tbl[v].a0, 5'd0);
            #1;
            chk($sformatf("vec%0d d0", v), rd_data[31:0], tbl[v].e_d0);
            chk($sformatf("vec%0d b0", v), 32'(rd_busy[0]),
                32'(tbl[v].e_b0));
            chk($sformatf("vec%0d cf", v), 32'(rsv_conflict),
                32'(tbl[v].e_cf));
            chk($sformatf("vec%0d nb_d0", v), nb_rd_data[31:0],
                tbl[v].e_nb);
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("vec%0d cnt", v), 32'(busy_count),
                32'(tbl[v].e_cnt));
            chk($sformatf("vec%0d nb_cnt", v), 32'(nb_busy_count),
                32'(tbl[v].e_cnt));
            @(negedge clk);
        end

        // Reserve x1..x4, then assert rst between edges.
        for (int r = 1; r <= 4; r++) begin
            set_in(0, 0, 0, 1, 5'(r), 0, 5'(r), 5'd5);
            #1;
            check_comb("rsv_seq");
            edge_and_count("rsv_seq");
        end
        set_in(1, 6, 32'h55, 0, 0, 0, 5'd1, 5'd5);
        #1;
        chk("pre_rst busy x1", 32'(rd_busy[0]), 32'h1);
        chk("pre_rst count", 32'(busy_count), 32'h4);
        #1;
        rst = 1'b1;
        #1;
        chk("async busy x1", 32'(rd_busy[0]), 32'h0);
        chk("async data x5", rd_data[63:32], 32'h0);
        chk("async count", 32'(busy_count), 32'h0);
        chk("async nb_count", 32'(nb_busy_count), 32'h0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 5'd6, 5'd5);
        #1;
        chk("rst drops wr x6", rd_data[31:0], 32'h0);
        chk("rst clears x5", rd_data[63:32], 32'h0);
        @(negedge clk);

        // Random traffic, hazards concentrated on low registers.
        for (int c = 0; c < 400; c++) begin
            set_in(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom), 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 15) == 0),
                   5'($urandom_range(0, 9)), 5'($urandom_range(0, 31)));
            #1;
            check_comb($sformatf("rnd%0d", c));
            edge_and_count($sformatf("rnd%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
